reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 119 +++++++++++
 tb/tb_reg_file_mp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, two registered read ports.
// Array zeroed by a sequential clear walk after reset or on request.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b0
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              RF_CLR,
    input  logic              RF_WE0,
    input  logic [ADDR_W-1:0] RF_WA0,
    input  logic [DATA_W-1:0] RF_WD0,
    input  logic              RF_WE1,
    input  logic [ADDR_W-1:0] RF_WA1,
    input  logic [DATA_W-1:0] RF_WD1,
    input  logic [ADDR_W-1:0] RF_ADR1,
    input  logic [ADDR_W-1:0] RF_ADR2,
    output logic [DATA_W-1:0] RF_RS1,
    output logic [DATA_W-1:0] RF_RS2,
    output logic              RF_BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic [DATA_W-1:0] ram [DEPTH];
    logic              acc0;
    logic              acc1;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // A write lands only in IDLE, outside reset and clear requests,
    // and never on the hardwired zero register.
    assign acc0 = RF_WE0 && !RST && !RF_CLR && (state == IDLE)
                  && !(ZERO_REG && (RF_WA0 == '0));
    assign acc1 = RF_WE1 && !RST && !RF_CLR && (state == IDLE)
                  && !(ZERO_REG && (RF_WA1 == '0));

    assign RF_BUSY = (state == CLEAR);

    // Read port 1 next value: array, optional forwarding, zero masks.
    always_comb begin
        rd1 = ram[RF_ADR1];
        if (BYPASS && acc0 && (RF_WA0 == RF_ADR1)) rd1 = RF_WD0;
        if (BYPASS && acc1 && (RF_WA1 == RF_ADR1)) rd1 = RF_WD1;
        if (ZERO_REG && (RF_ADR1 == '0)) rd1 = '0;
        if (state == CLEAR) rd1 = '0;
    end

    // Read port 2 next value, same rules as port 1.
    always_comb begin
        rd2 = ram[RF_ADR2];
        if (BYPASS && acc0 && (RF_WA0 == RF_ADR2)) rd2 = RF_WD0;
        if (BYPASS && acc1 && (RF_WA1 == RF_ADR2)) rd2 = RF_WD1;
        if (ZERO_REG && (RF_ADR2 == '0)) rd2 = '0;
        if (state == CLEAR) rd2 = '0;
    end

    // Clear sequencer next state: walk CNT over every entry once.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (RF_CLR) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (&cnt) state_next = IDLE;
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and registered read data; reset restarts the clear.
    always_ff @(posedge clk) begin
        if (RST) begin
            state  <= CLEAR;
            cnt    <= '0;
            RF_RS1 <= '0;
            RF_RS2 <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            RF_RS1 <= rd1;
            RF_RS2 <= rd2;
        end
    end

    // Array update: clear walk in CLEAR, otherwise port 0 then port 1
    // so port 1 wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (!RST) begin
            if (state == CLEAR) begin
                ram[cnt] <= '0;
            end else begin
                if (acc0) ram[RF_WA0] <= RF_WD0;
                if (acc1) ram[RF_WA1] <= RF_WD1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed bench for reg_file_mp.
// Two instances (no bypass / bypass) share stimulus and a reference model.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        we0 = 1'b0;
    logic [4:0]  wa0 = '0;
    logic [31:0] wd0 = '0;
    logic        we1 = 1'b0;
    logic [4:0]  wa1 = '0;
    logic [31:0] wd1 = '0;
    logic [4:0]  adr1 = '0;
    logic [4:0]  adr2 = '0;
    logic [31:0] rs1_0, rs2_0, rs1_1, rs2_1;
    logic        busy0, busy1;

    int checks = 0;
    int failures = 0;

    logic [31:0] m [32];
    int          busy_left = 0;
    logic [31:0] e1_0, e2_0, e1_1, e2_1;
    logic        ebusy;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1'b0)) dut0 (
        .clk(clk), .RST(rst), .RF_CLR(clr),
        .RF_WE0(we0), .RF_WA0(wa0), .RF_WD0(wd0),
        .RF_WE1(we1), .RF_WA1(wa1), .RF_WD1(wd1),
        .RF_ADR1(adr1), .RF_ADR2(adr2),
        .RF_RS1(rs1_0), .RF_RS2(rs2_0), .RF_BUSY(busy0)
    );

    reg_file_mp #(.BYPASS(1'b1)) dut1 (
        .clk(clk), .RST(rst), .RF_CLR(clr),
        .RF_WE0(we0), .RF_WA0(wa0), .RF_WD0(wd0),
        .RF_WE1(we1), .RF_WA1(wa1), .RF_WD1(wd1),
        .RF_ADR1(adr1), .RF_ADR2(adr2),
        .RF_RS1(rs1_1), .RF_RS2(rs2_1), .RF_BUSY(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Value a read of address a returns, given this edge's inputs.
    function automatic logic [31:0] model_rd(input logic [4:0] a,
                                             input bit byp);
        logic [31:0] v;
        bit ok0, ok1;
        ok0 = we0 && !clr && (wa0 != 5'd0);
        ok1 = we1 && !clr && (wa1 != 5'd0);
        v = m[a];
        if (byp) begin
            if (ok1 && wa1 == a)      v = wd1;
            else if (ok0 && wa0 == a) v = wd0;
        end
        if (a == 5'd0) v = 32'h0;
        return v;
    endfunction

    // One clock edge of the reference model.
    task automatic step();
        if (rst) begin
            busy_left = 32;
            e1_0 = 0; e2_0 = 0; e1_1 = 0; e2_1 = 0;
        end else if (busy_left > 0) begin
            m[32 - busy_left] = 32'h0;
            busy_left--;
            e1_0 = 0; e2_0 = 0; e1_1 = 0; e2_1 = 0;
        end else begin
            e1_0 = model_rd(adr1, 1'b0);
            e2_0 = model_rd(adr2, 1'b0);
            e1_1 = model_rd(adr1, 1'b1);
            e2_1 = model_rd(adr2, 1'b1);
            if (clr) begin
                busy_left = 32;
            end else begin
                if (we0 && wa0 != 5'd0) m[wa0] = wd0;
                if (we1 && wa1 != 5'd0) m[wa1] = wd1;
            end
        end
        ebusy = (busy_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        step();
        @(negedge clk);
        check("busy0", {31'h0, busy0}, {31'h0, ebusy});
        check("busy1", {31'h0, busy1}, {31'h0, ebusy});
        check("rs1_nb", rs1_0, e1_0);
        check("rs2_nb", rs2_0, e2_0);
        check("rs1_by", rs1_1, e1_1);
        check("rs2_by", rs2_1, e2_1);
    endtask

    task automatic idle_in();
        clr = 0; we0 = 0; we1 = 0; rst = 0;
    endtask

    // Counts busy samples, starting from one already seen high.
    task automatic busy_len(input string tag);
        int n;
        n = 1;
        while (n < 100) begin
            tick();
            if (!busy0) break;
            n++;
        end
        check(tag, n, 32);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        // reset release and full clear
        rst = 1;
        tick();
        check("rst_busy", {31'h0, busy0}, 32'h1);
        idle_in();
        busy_len("busy_len_rst");
        for (int i = 0; i < 32; i++) begin
            adr1 = 5'(i); adr2 = 5'(31 - i);
            tick();
        end
        // write / read, zero register
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
        tick();
        we0 = 0; adr1 = 5;
        tick();
        tick();
        check("rd5", rs1_0, 32'hDEADBEEF);
        we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF;
        tick();
        we0 = 0; adr2 = 0;
        tick();
        tick();
        check("rd0", rs2_0, 32'h0);
        // dual write conflict and split
        we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h11; wd1 = 32'h22;
        tick();
        we0 = 0; we1 = 0; adr1 = 7;
        tick();
        tick();
        check("conf7", rs1_0, 32'h22);
        we0 = 1; we1 = 1; wa0 = 3; wa1 = 4; wd0 = 32'h33; wd1 = 32'h44;
        tick();
        we0 = 0; we1 = 0; adr1 = 3; adr2 = 4;
        tick();
        tick();
        check("split3", rs1_0, 32'h33);
        check("split4", rs2_0, 32'h44);
        // bypass vs old value
        we0 = 1; wa0 = 9; wd0 = 32'h12345678;
        tick();
        we0 = 1; wa0 = 9; wd0 = 32'hA5A5A5A5; adr1 = 9;
        tick();
        check("byp_on", rs1_1, 32'hA5A5A5A5);
        check("byp_off", rs1_0, 32'h12345678);
        we0 = 1; we1 = 1; wa0 = 10; wa1 = 10;
        wd0 = 32'hAAAA0000; wd1 = 32'hBBBB1111; adr2 = 10;
        tick();
        check("byp_p1", rs2_1, 32'hBBBB1111);
        idle_in();
        // clear with write attempt and second clear mid-way
        for (int i = 1; i <= 12; i++) begin
            we0 = 1; wa0 = 5'(i); wd0 = 32'h100 + 32'(i);
            tick();
        end
        we0 = 1; wa0 = 12; wd0 = 32'hCAFE; clr = 1;
        tick();
        idle_in();
        check("clr_busy", {31'h0, busy0}, 32'h1);
        for (int n = 1; n < 100; n++) begin
            we0 = (n == 3); wa0 = 12; wd0 = 32'hBAD0_0012;
            clr = (n == 15);
            tick();
            if (!busy0) begin
                check("busy_len_clr", n, 32);
                break;
            end
        end
        idle_in();
        adr1 = 12;
        tick();
        tick();
        check("lost12", rs1_0, 32'h0);
        // reset mid-clear
        for (int i = 1; i <= 5; i++) begin
            we1 = 1; wa1 = 5'(i + 20); wd1 = $urandom;
            tick();
        end
        idle_in();
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 15; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        busy_len("busy_len_rst2");
        // random traffic
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 39) == 0);
            we0 = $urandom_range(0, 1) == 1;
            we1 = $urandom_range(0, 1) == 1;
            wa0 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                               : 5'($urandom_range(0, 31));
            wa1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                               : 5'($urandom_range(0, 31));
            adr1 = ($urandom_range(0, 1) == 1) ? wa0
                                                : 5'($urandom_range(0, 31));
            adr2 = ($urandom_range(0, 1) == 1) ? wa1
                                                : 5'($urandom_range(0, 7));
            wd0 = $urandom;
            wd1 = $urandom;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
